// File: rtl/neuron_mac_if.sv
// Operand/result handshake bundle for neuron_mac: start+bias, (x, w) beat stream, z result stream.
interface neuron_mac_if;
  logic               start;
  logic signed [15:0] bias;
  logic        [7:0]  x;
  logic signed [7:0]  w;
  logic               in_valid;
  logic               in_ready;
  logic        [7:0]  z;
  logic               sat;
  logic               z_valid;
  logic               z_ready;

  modport master (
    output start, bias, x, w, in_valid, z_ready,
    input  in_ready, z, sat, z_valid
  );

  modport slave (
    input  start, bias, x, w, in_valid, z_ready,
    output in_ready, z, sat, z_valid
  );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: bias + sum of N (x*w) beats, shifted and clamped to an 8-bit z.
// state | meaning
// IDLE  | waiting for start; bias loads into acc on start
// ACC   | accepting (x, w) beats; in_ready high
// OUT   | z/sat presented with z_valid until z_ready
module neuron_mac #(
  parameter int N     = 4,
  parameter int SHIFT = 4
) (
  input logic        clk,
  input logic        rst,
  neuron_mac_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [7:0] LAST = 8'(N - 1);

  state_t             state_q, state_d;
  logic signed [23:0] acc_q, acc_d;
  logic        [7:0]  cnt_q, cnt_d;
  logic        [7:0]  z_q, z_d;
  logic               sat_q, sat_d;

  logic signed [15:0] prod;
  logic signed [23:0] sum_s;
  logic signed [23:0] shifted;
  logic        [7:0]  clamp_z;
  logic               clamp_sat;

  // x is unsigned, so it gets a zero sign bit before the signed multiply
  assign prod    = $signed({1'b0, bus.x}) * $signed(bus.w);
  assign sum_s   = acc_q + {{8{prod[15]}}, prod};
  assign shifted = sum_s >>> SHIFT;

  always_comb begin
    clamp_z   = shifted[7:0];
    clamp_sat = 1'b0;
    if (shifted < 0) begin
      clamp_z   = 8'd0;
      clamp_sat = 1'b1;
    end else if (shifted > 24'sd255) begin
      clamp_z   = 8'd255;
      clamp_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = {{8{bus.bias[15]}}, bus.bias};
          cnt_d   = 8'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = sum_s;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) begin
            z_d     = clamp_z;
            sat_d   = clamp_sat;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.z_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
    end
  end

  // every output comes straight from a flop, so no input reaches an output combinationally
  assign bus.in_ready = (state_q == ACC);
  assign bus.z_valid  = (state_q == OUT);
  assign bus.z        = z_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed bench for neuron_mac; results are scoreboarded against an integer model.
module tb_neuron_mac;

  localparam int N     = 4;
  localparam int SHIFT = 4;

  logic clk;
  logic rst;

  neuron_mac_if bus ();

  neuron_mac #(.N(N), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int bx[N];
  int bw[N];

  function automatic void check(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endfunction

  // reference: plain integer dot product, arithmetic shift, clamp to 0..255
  function automatic logic [8:0] model(int b);
    int sum;
    int s;
    sum = b;
    for (int i = 0; i < N; i++) sum += bx[i] * bw[i];
    s = sum >>> SHIFT;
    if (s < 0)   return {1'b1, 8'd0};
    if (s > 255) return {1'b1, 8'd255};
    return {1'b0, 8'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && bus.z_valid && bus.z_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=z%0d required=no_output at %0t", bus.z, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_z", int'(bus.z), int'(e[7:0]));
        check("sb_sat", int'(bus.sat), int'(e[8]));
      end
    end
  end

  task automatic run_neuron(input int b, input int max_gap, input int stall);
    logic [8:0] e;
    int gaps;
    e = model(b);
    bus.start = 1'b1;
    bus.bias  = 16'(b);
    tick();
    bus.start = 1'b0;
    check("in_ready_acc", int'(bus.in_ready), 1);
    for (int i = 0; i < N; i++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gaps) begin
        bus.in_valid = 1'b0;
        bus.x = 8'($urandom);
        bus.w = 8'($urandom);
        tick();
        check("gap_no_zvalid", int'(bus.z_valid), 0);
      end
      bus.in_valid = 1'b1;
      bus.x = 8'(bx[i]);
      bus.w = 8'(bw[i]);
      if (i == N - 1) exp_q.push_back(e);
      tick();
      bus.in_valid = 1'b0;
      check("z_valid_latency", int'(bus.z_valid), (i == N - 1) ? 1 : 0);
    end
    repeat (stall) begin
      bus.start = 1'b1;
      tick();
      check("stall_z_valid", int'(bus.z_valid), 1);
      check("stall_z", int'(bus.z), int'(e[7:0]));
      check("stall_sat", int'(bus.sat), int'(e[8]));
      check("stall_in_ready", int'(bus.in_ready), 0);
    end
    bus.start   = 1'b1;
    bus.z_ready = 1'b1;
    tick();
    bus.z_ready = 1'b0;
    bus.start   = 1'b0;
    check("post_hs_z_valid", int'(bus.z_valid), 0);
    check("post_hs_in_ready", int'(bus.in_ready), 0);
    check("post_hs_z_hold", int'(bus.z), int'(e[7:0]));
    check("post_hs_sat_hold", int'(bus.sat), int'(e[8]));
    tick();
    check("hs_start_ignored", int'(bus.in_ready), 0);
  endtask

  task automatic set_beats(input int xv, input int wv);
    for (int i = 0; i < N; i++) begin
      bx[i] = xv;
      bw[i] = wv;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.bias     = '0;
    bus.x        = '0;
    bus.w        = '0;
    bus.in_valid = 1'b0;
    bus.z_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_z", int'(bus.z), 0);
    check("rst_sat", int'(bus.sat), 0);
    check("rst_z_valid", int'(bus.z_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    tick();
    check("idle_no_start", int'(bus.in_ready), 0);

    set_beats(16, 1);     run_neuron(0, 0, 0);
    set_beats(10, -5);    run_neuron(-100, 0, 1);
    set_beats(255, 127);  run_neuron(0, 0, 0);
    set_beats(0, 0);
    for (int i = 0; i < N; i++) bw[i] = int'($urandom_range(0, 255)) - 128;
    run_neuron(80, 3, 0);
    set_beats(16, 1);     run_neuron(0, 2, 5);

    // abort mid-evaluation after two accepted beats
    bus.start = 1'b1;
    bus.bias  = 16'sd1000;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.x = 8'd200;
      bus.w = 8'sd100;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_z", int'(bus.z), 0);
    check("abort_sat", int'(bus.sat), 0);
    check("abort_z_valid", int'(bus.z_valid), 0);
    check("abort_in_ready", int'(bus.in_ready), 0);
    tick();
    check("abort_idle", int'(bus.in_ready), 0);
    check("abort_no_result", exp_q.size(), 0);
    set_beats(16, 1);     run_neuron(0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        bx[i] = int'($urandom_range(0, 255));
        bw[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_neuron(int'($urandom_range(0, 65535)) - 32768, 2, int'($urandom_range(0, 3)));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
